// File: rtl/db_addr_gen_pkg.sv
// Shared definitions for the double-buffer read-address generator.
//   - state_e      : controller state encoding (IDLE, RUN, DONE)
//   - *_DEF        : default geometry (dimensions, address width, range width)
//   - clamp_dims   : maps a requested dimensionality onto the supported range
package db_addr_gen_pkg;

    localparam int NUM_DIMS_DEF = 6;
    localparam int ADDR_W_DEF   = 16;
    localparam int RANGE_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A dimensionality of 0 behaves as a single loop; anything beyond the
    // supported depth is limited to the deepest supported nest.
    function automatic logic [3:0] clamp_dims(input logic [3:0] dims,
                                              input logic [3:0] max_dims);
        logic [3:0] res;
        if (dims == 4'd0) begin
            res = 4'd1;
        end else if (dims > max_dims) begin
            res = max_dims;
        end else begin
            res = dims;
        end
        return res;
    endfunction

endpackage

// File: rtl/db_iter_counter.sv
// Nested loop index counters for the read-address generator.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   clr             : return every index to zero (start of pass / abort)
//   inc             : advance the nest by one iteration
//   act_mask        : bit i set when dimension i takes part in the nest
//   range_flat      : per-dimension trip counts (already normalised to >= 1)
//   idx_flat        : current index of each dimension
//   carry_dim       : lowest active dimension that does not wrap on the next
//                     increment (NUM_DIMS when every active dimension wraps)
//   all_wrap        : every active dimension sits at its final index
module db_iter_counter
    import db_addr_gen_pkg::*;
#(
    parameter int NUM_DIMS = NUM_DIMS_DEF,
    parameter int RANGE_W  = RANGE_W_DEF,
    parameter int DIM_W    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        inc,
    input  logic [NUM_DIMS-1:0]         act_mask,
    input  logic [NUM_DIMS*RANGE_W-1:0] range_flat,
    output logic [NUM_DIMS*RANGE_W-1:0] idx_flat,
    output logic [DIM_W-1:0]            carry_dim,
    output logic                        all_wrap
);

    logic [NUM_DIMS-1:0] wrap_s;

    // Per-dimension wrap flags, carry-stop search (lowest index wins) and the
    // "whole nest at its final point" indication.
    always_comb begin
        wrap_s    = '0;
        carry_dim = DIM_W'(NUM_DIMS);
        for (int i = 0; i < NUM_DIMS; i++) begin
            wrap_s[i] = act_mask[i] &&
                        (idx_flat[i*RANGE_W +: RANGE_W] ==
                         range_flat[i*RANGE_W +: RANGE_W] - RANGE_W'(1'b1));
        end
        for (int i = NUM_DIMS - 1; i >= 0; i--) begin
            if (act_mask[i] && !wrap_s[i]) begin
                carry_dim = DIM_W'(i);
            end else begin
                carry_dim = carry_dim;
            end
        end
        all_wrap = &(wrap_s | ~act_mask);
    end

    // Index registers: dimensions below the carry stop wrap to zero, the
    // carry-stop dimension increments, higher ones hold; inactive ones stay 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_flat <= '0;
        end else if (clr) begin
            idx_flat <= '0;
        end else if (inc) begin
            for (int i = 0; i < NUM_DIMS; i++) begin
                if (!act_mask[i]) begin
                    idx_flat[i*RANGE_W +: RANGE_W] <= '0;
                end else if (i < int'(carry_dim)) begin
                    idx_flat[i*RANGE_W +: RANGE_W] <= '0;
                end else if (i == int'(carry_dim)) begin
                    idx_flat[i*RANGE_W +: RANGE_W] <=
                        idx_flat[i*RANGE_W +: RANGE_W] + RANGE_W'(1'b1);
                end else begin
                    idx_flat[i*RANGE_W +: RANGE_W] <= idx_flat[i*RANGE_W +: RANGE_W];
                end
            end
        end else begin
            idx_flat <= idx_flat;
        end
    end

endmodule

// File: rtl/db_read_addr_gen.sv
// Iteration-domain read-address generator feeding the double-buffer core's
// read port. Walks up to NUM_DIMS nested loops (stride/range per dimension)
// from a base address and emits one address per accepted handshake.
// Ports:
//   clk, reset                : clock, synchronous active-low reset
//   clk_en                    : global step enable (flush/reset ignore it)
//   flush                     : abort to IDLE without a done pulse
//   start                     : begin a pass (IDLE only)
//   dimensionality            : active loop depth (0 -> 1, clamped to NUM_DIMS)
//   starting_addr, iter_cnt   : base address, cap on addresses per pass
//   stride_flat, range_flat   : per-dimension stride / trip count (0 -> 1)
//   addr_valid/ready/out/last : address stream towards the core
//   busy, done                : pass in progress, one-cycle end-of-pass pulse
module db_read_addr_gen
    import db_addr_gen_pkg::*;
#(
    parameter int NUM_DIMS = NUM_DIMS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RANGE_W  = RANGE_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_en,
    input  logic                        flush,
    input  logic                        start,
    input  logic [3:0]                  dimensionality,
    input  logic [ADDR_W-1:0]           starting_addr,
    input  logic [RANGE_W-1:0]          iter_cnt,
    input  logic [NUM_DIMS*ADDR_W-1:0]  stride_flat,
    input  logic [NUM_DIMS*RANGE_W-1:0] range_flat,
    output logic                        addr_valid,
    input  logic                        addr_ready,
    output logic [ADDR_W-1:0]           addr_out,
    output logic                        addr_last,
    output logic                        busy,
    output logic                        done
);

    localparam int DIM_W = $clog2(NUM_DIMS + 1);

    state_e                      state_r;
    logic [NUM_DIMS-1:0]         act_mask_r;
    logic [NUM_DIMS*ADDR_W-1:0]  stride_r;
    logic [NUM_DIMS*RANGE_W-1:0] range_r;
    logic [RANGE_W-1:0]          iter_r;
    logic [RANGE_W-1:0]          emit_r;
    logic [ADDR_W-1:0]           addr_r;
    logic                        valid_r;
    logic                        last_r;
    logic                        busy_r;
    logic                        done_r;

    logic [3:0]                  dims_in_s;
    logic [NUM_DIMS-1:0]         act_mask_in_s;
    logic [NUM_DIMS*RANGE_W-1:0] range_in_s;
    logic                        ones_in_s;
    logic                        first_last_s;
    logic                        start_acc_s;
    logic                        xfer_s;
    logic                        cnt_clr_s;

    logic [NUM_DIMS*RANGE_W-1:0] idx_s;
    logic [DIM_W-1:0]            carry_dim_s;
    logic                        all_wrap_s;
    logic [ADDR_W-1:0]           delta_s;
    logic                        wrap_nxt_s;
    logic                        cap_nxt_s;

    assign addr_valid = valid_r;
    assign addr_out   = addr_r;
    assign addr_last  = last_r;
    assign busy       = busy_r;
    assign done       = done_r;

    // Handshake qualifiers: RUN is the only state with valid_r set.
    always_comb begin
        start_acc_s = clk_en && start && (state_r == ST_IDLE);
        xfer_s      = valid_r && addr_ready && clk_en;
        cnt_clr_s   = flush || start_acc_s;
    end

    // Normalise the incoming configuration so it can be latched at start, and
    // decide whether the very first address already ends the pass.
    always_comb begin
        dims_in_s     = clamp_dims(dimensionality, 4'(NUM_DIMS));
        act_mask_in_s = '0;
        range_in_s    = '0;
        ones_in_s     = 1'b1;
        for (int i = 0; i < NUM_DIMS; i++) begin
            act_mask_in_s[i] = (4'(i) < dims_in_s);
            if (range_flat[i*RANGE_W +: RANGE_W] == '0) begin
                range_in_s[i*RANGE_W +: RANGE_W] = RANGE_W'(1'b1);
            end else begin
                range_in_s[i*RANGE_W +: RANGE_W] = range_flat[i*RANGE_W +: RANGE_W];
            end
            if (act_mask_in_s[i] && (range_in_s[i*RANGE_W +: RANGE_W] != RANGE_W'(1'b1))) begin
                ones_in_s = 1'b0;
            end else begin
                ones_in_s = ones_in_s;
            end
        end
        first_last_s = ones_in_s || (iter_cnt == RANGE_W'(1'b1));
    end

    // Incremental address step and look-ahead of addr_last for the next
    // address. Below the carry stop each dimension rewinds by
    // (range-1)*stride; the carry-stop dimension advances by its stride.
    // The next point is final when the rewound dimensions have range 1, the
    // carry-stop index lands on its last value and everything above already
    // sits at its last value.
    always_comb begin
        delta_s    = '0;
        wrap_nxt_s = 1'b1;
        for (int j = 0; j < NUM_DIMS; j++) begin
            if (!act_mask_r[j]) begin
                wrap_nxt_s = wrap_nxt_s;
            end else if (j < int'(carry_dim_s)) begin
                delta_s = delta_s - ADDR_W'((range_r[j*RANGE_W +: RANGE_W] - RANGE_W'(1'b1)) *
                                            RANGE_W'(stride_r[j*ADDR_W +: ADDR_W]));
                wrap_nxt_s = wrap_nxt_s && (range_r[j*RANGE_W +: RANGE_W] == RANGE_W'(1'b1));
            end else if (j == int'(carry_dim_s)) begin
                delta_s    = delta_s + stride_r[j*ADDR_W +: ADDR_W];
                wrap_nxt_s = wrap_nxt_s &&
                             (idx_s[j*RANGE_W +: RANGE_W] + RANGE_W'(1'b1) ==
                              range_r[j*RANGE_W +: RANGE_W] - RANGE_W'(1'b1));
            end else begin
                wrap_nxt_s = wrap_nxt_s &&
                             (idx_s[j*RANGE_W +: RANGE_W] ==
                              range_r[j*RANGE_W +: RANGE_W] - RANGE_W'(1'b1));
            end
        end
        // A fully wrapped nest has no successor inside this pass.
        if (all_wrap_s) begin
            delta_s = '0;
        end else begin
            delta_s = delta_s;
        end
        cap_nxt_s = (emit_r + RANGE_W'(1'b1) == iter_r - RANGE_W'(1'b1));
    end

    db_iter_counter #(
        .NUM_DIMS (NUM_DIMS),
        .RANGE_W  (RANGE_W),
        .DIM_W    (DIM_W)
    ) u_iter (
        .clk        (clk),
        .reset      (reset),
        .clr        (cnt_clr_s),
        .inc        (xfer_s),
        .act_mask   (act_mask_r),
        .range_flat (range_r),
        .idx_flat   (idx_s),
        .carry_dim  (carry_dim_s),
        .all_wrap   (all_wrap_s)
    );

    // Controller FSM with configuration latch, emit counter, address register
    // and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            act_mask_r <= '0;
            stride_r   <= '0;
            range_r    <= '0;
            iter_r     <= '0;
            emit_r     <= '0;
            addr_r     <= '0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (flush) begin
            state_r <= ST_IDLE;
            emit_r  <= '0;
            addr_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (clk_en) begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        act_mask_r <= act_mask_in_s;
                        stride_r   <= stride_flat;
                        range_r    <= range_in_s;
                        iter_r     <= iter_cnt;
                        emit_r     <= '0;
                        addr_r     <= starting_addr;
                        busy_r     <= 1'b1;
                        if (iter_cnt == '0) begin
                            // Nothing to emit: report completion straight away.
                            state_r <= ST_DONE;
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            valid_r <= 1'b1;
                            last_r  <= first_last_s;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (addr_ready) begin
                        if (last_r) begin
                            state_r <= ST_DONE;
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            addr_r <= addr_r + delta_s;
                            last_r <= wrap_nxt_s || cap_nxt_s;
                            emit_r <= emit_r + RANGE_W'(1'b1);
                        end
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule
